csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: csr_w_enabled  in  1  write strobe from writeback stage.
REQ-004 SHALL have port: csr_w_addr  in  12  write address.
REQ-005 SHALL have port: csr_w_data  in  32  write data.
REQ-006 SHALL have port: csr_r_addr  in  12  read address from execute stage.
REQ-007 SHALL have port: csr_r_data  out  32  read data, combinational.
REQ-008 SHALL have port: csr_r_illegal  out  1  high when csr_r_addr is not implemented.
REQ-009 SHALL have port: retired  in  1  one-cycle pulse per committed instruction.
REQ-010 SHALL have port: trap_valid  in  1  trap entry request.
REQ-011 SHALL have port: trap_pc  in  32  pc of trapping instruction.
REQ-012 SHALL have port: trap_cause  in  32  mcause value for the trap.
REQ-013 SHALL have port: mret  in  1  mret commit pulse.
REQ-014 SHALL have port: mtvec_out  out  32  current trap vector.
REQ-015 SHALL have port: mepc_out  out  32  current return pc.
REQ-016 SHALL have parameter: HARTID, default 0, value returned by mhartid.

Function
REQ-017 SHALL implement RW: mstatus 0x300 (only MIE bit3, MPIE bit7 writable, others read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
REQ-018 SHALL implement RO: misa 0x301 = 0x40000100, mhartid 0xF14 = HARTID, mip 0x344 = 0.
REQ-019 SHALL implement 64-bit counters mcycle (0xB00 low, 0xB80 high) and minstret (0xB02 low, 0xB82 high), RW.
REQ-020 SHALL mirror counters read-only at cycle 0xC00/0xC80, instret 0xC02/0xC82.
REQ-021 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write (direct mode, 4-byte aligned).
REQ-022 SHALL return unimplemented reads as csr_r_data=0 with csr_r_illegal=1; implemented reads give illegal=0.
REQ-023 SHALL ignore writes to RO or unimplemented addresses with no state change.
REQ-024 SHALL make writes visible on csr_r_data the cycle after the strobe; same-cycle read returns the old value.
REQ-025 SHALL increment mcycle by 1 every cycle out of reset, carrying from low into high word, wrapping 2^64-1 to 0.
REQ-026 SHALL increment minstret by 1 in each cycle with retired=1, same carry and wrap rules.
REQ-027 SHALL let a software write to a counter half win over that cycle's increment; the other half keeps its old value (no carry applied).
REQ-028 SHALL on trap_valid: mepc<=trap_pc with [1:0]=0, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-029 SHALL on mret (without trap_valid): MIE<=MPIE, MPIE<=1.
REQ-030 SHALL give trap_valid priority over mret, and trap/mret over a same-cycle csr write to affected fields; unaffected CSRs still take the write.
REQ-031 SHALL drive mtvec_out and mepc_out straight from the registers (no extra latency).

Reset
REQ-032 SHALL on rstn=0 at a clock edge clear all RW CSRs and both counters to 0; the cycle after release shows mcycle=0, then increments.
REQ-033 SHALL ignore writes, retired, trap_valid and mret while rstn=0; reset mid-trap discards the trap.

Structure
REQ-034 SHALL put CSR address constants, mstatus bit indices and the misa value in the shared def package.
REQ-035 SHALL use one sub-module counter64 (load_lo, load_hi, inc, 64-bit value), instantiated twice.

Verification
REQ-036 SHALL cover: write mscratch=0xDEADBEEF, read 0x340 next cycle -> 0xDEADBEEF, illegal=0; same-cycle read -> old value 0.
REQ-037 SHALL cover: write 0x0000_0007 to mtvec -> readback 0x0000_0004; write 0x7C0 (unimplemented) -> read 0, illegal=1.
REQ-038 SHALL cover: write mcycle low=0xFFFFFFFF, high=0 -> next cycles read low=0, high=1 (carry).
REQ-039 SHALL cover: 5 retired pulses over 8 cycles from reset -> minstret=5, instret 0xC02=5; write to 0xC02 ignored.
REQ-040 SHALL cover: MIE=1, trap_valid with pc=0x103, cause=0xB, plus same-cycle mret -> mepc=0x100, mcause=0xB, MIE=0, MPIE=1; later mret -> MIE=1.
REQ-041 SHALL cover: rstn low for one cycle mid-count -> all CSRs 0, counting restarts from 0.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, mstatus bit
// positions, fixed read-only values and an alignment helper.
package csr_file_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

   // mtvec and mepc only hold 4-byte aligned addresses
   function automatic logic [31:0] align4(input logic [31:0] v);
      return v & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit counter with independent software loads of each 32-bit half.
// A load wins over the increment and leaves the other half untouched.
module counter64 (
   input  logic        clk,
   input  logic        rstn,
   input  logic        load_lo,
   input  logic        load_hi,
   input  logic [31:0] wdata,
   input  logic        inc,
   output logic [63:0] value
);

   logic [63:0] value_q;
   logic [63:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load_lo) begin
         value_d[31:0] = wdata;
      end else if (load_hi) begin
         value_d[63:32] = wdata;
      end else if (inc) begin
         value_d = value_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: one write port from writeback, one combinational
// read port for execute, trap/mret side effects and the two 64-bit counters.
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] HARTID = 32'd0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        csr_w_enabled,
   input  logic [11:0] csr_w_addr,
   input  logic [31:0] csr_w_data,
   input  logic [11:0] csr_r_addr,
   output logic [31:0] csr_r_data,
   output logic        csr_r_illegal,
   input  logic        retired,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic        mret,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out
);

   logic        st_mie_q,  st_mie_d;
   logic        st_mpie_q, st_mpie_d;
   logic [31:0] mie_q,      mie_d;
   logic [31:0] mtvec_q,    mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q,     mepc_d;
   logic [31:0] mcause_q,   mcause_d;
   logic [31:0] mtval_q,    mtval_d;

   logic [63:0] mcycle;
   logic [63:0] minstret;

   logic wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;

   assign wr_mcycle_lo   = csr_w_enabled && (csr_w_addr == CSR_MCYCLE);
   assign wr_mcycle_hi   = csr_w_enabled && (csr_w_addr == CSR_MCYCLEH);
   assign wr_minstret_lo = csr_w_enabled && (csr_w_addr == CSR_MINSTRET);
   assign wr_minstret_hi = csr_w_enabled && (csr_w_addr == CSR_MINSTRETH);

   counter64 u_mcycle (
      .clk     (clk),
      .rstn    (rstn),
      .load_lo (wr_mcycle_lo),
      .load_hi (wr_mcycle_hi),
      .wdata   (csr_w_data),
      .inc     (1'b1),
      .value   (mcycle)
   );

   counter64 u_minstret (
      .clk     (clk),
      .rstn    (rstn),
      .load_lo (wr_minstret_lo),
      .load_hi (wr_minstret_hi),
      .wdata   (csr_w_data),
      .inc     (retired),
      .value   (minstret)
   );

   always_comb begin
      st_mie_d   = st_mie_q;
      st_mpie_d  = st_mpie_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;

      if (csr_w_enabled) begin
         case (csr_w_addr)
            CSR_MSTATUS: begin
               st_mie_d  = csr_w_data[MSTATUS_MIE];
               st_mpie_d = csr_w_data[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_d      = csr_w_data;
            CSR_MTVEC:    mtvec_d    = align4(csr_w_data);
            CSR_MSCRATCH: mscratch_d = csr_w_data;
            CSR_MEPC:     mepc_d     = align4(csr_w_data);
            CSR_MCAUSE:   mcause_d   = csr_w_data;
            CSR_MTVAL:    mtval_d    = csr_w_data;
            default: ;
         endcase
      end

      // Trap/mret are applied last so they override a software write to the same fields
      if (trap_valid) begin
         mepc_d    = align4(trap_pc);
         mcause_d  = trap_cause;
         st_mpie_d = st_mie_q;
         st_mie_d  = 1'b0;
      end else if (mret) begin
         st_mie_d  = st_mpie_q;
         st_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st_mie_q   <= 1'b0;
         st_mpie_q  <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         st_mie_q   <= st_mie_d;
         st_mpie_q  <= st_mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   always_comb begin
      csr_r_data    = '0;
      csr_r_illegal = 1'b0;
      case (csr_r_addr)
         CSR_MSTATUS: begin
            csr_r_data[MSTATUS_MIE]  = st_mie_q;
            csr_r_data[MSTATUS_MPIE] = st_mpie_q;
         end
         CSR_MISA:      csr_r_data = MISA_VALUE;
         CSR_MIE:       csr_r_data = mie_q;
         CSR_MTVEC:     csr_r_data = mtvec_q;
         CSR_MSCRATCH:  csr_r_data = mscratch_q;
         CSR_MEPC:      csr_r_data = mepc_q;
         CSR_MCAUSE:    csr_r_data = mcause_q;
         CSR_MTVAL:     csr_r_data = mtval_q;
         CSR_MIP:       csr_r_data = '0;
         CSR_MHARTID:   csr_r_data = HARTID;
         CSR_MCYCLE,
         CSR_CYCLE:     csr_r_data = mcycle[31:0];
         CSR_MCYCLEH,
         CSR_CYCLEH:    csr_r_data = mcycle[63:32];
         CSR_MINSTRET,
         CSR_INSTRET:   csr_r_data = minstret[31:0];
         CSR_MINSTRETH,
         CSR_INSTRETH:  csr_r_data = minstret[63:32];
         default:       csr_r_illegal = 1'b1;
      endcase
   end

   assign mtvec_out = mtvec_q;
   assign mepc_out  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: linear stimulus with hand-computed expectations
// checked by immediate assertions.
`timescale 1ns/1ps
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rstn;
   logic        csr_w_enabled;
   logic [11:0] csr_w_addr;
   logic [31:0] csr_w_data;
   logic [11:0] csr_r_addr;
   logic [31:0] csr_r_data;
   logic        csr_r_illegal;
   logic        retired;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        mret;
   logic [31:0] mtvec_out;
   logic [31:0] mepc_out;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   csr_file #(.HARTID(32'h0000_0005)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .csr_w_enabled (csr_w_enabled),
      .csr_w_addr    (csr_w_addr),
      .csr_w_data    (csr_w_data),
      .csr_r_addr    (csr_r_addr),
      .csr_r_data    (csr_r_data),
      .csr_r_illegal (csr_r_illegal),
      .retired       (retired),
      .trap_valid    (trap_valid),
      .trap_pc       (trap_pc),
      .trap_cause    (trap_cause),
      .mret          (mret),
      .mtvec_out     (mtvec_out),
      .mepc_out      (mepc_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic exp_ill);
      csr_r_addr = a;
      #1;
      $display("rd %-14s addr=0x%03h data=0x%08h illegal=%0b", tag, a, csr_r_data, csr_r_illegal);
      chk(tag, csr_r_data, exp);
      chk({tag, "_ill"}, {31'd0, csr_r_illegal}, {31'd0, exp_ill});
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_w_enabled = 1'b1;
      csr_w_addr    = a;
      csr_w_data    = d;
      $display("wr addr=0x%03h data=0x%08h", a, d);
      tick();
      csr_w_enabled = 1'b0;
   endtask

   logic [7:0] ret_pat;

   initial begin
      rstn = 1'b0; csr_w_enabled = 1'b0; csr_w_addr = '0; csr_w_data = '0;
      csr_r_addr = '0; retired = 1'b0; trap_valid = 1'b0; trap_pc = '0;
      trap_cause = '0; mret = 1'b0;
      ret_pat = 8'b0110_1011;

      tick(); tick();
      rd("rst_mcycle", 12'hB00, 32'h0, 1'b0);
      rd("rst_mstatus", 12'h300, 32'h0, 1'b0);

      // Activity during reset is discarded
      csr_w_enabled = 1'b1; csr_w_addr = 12'h340; csr_w_data = 32'h1111_1111;
      trap_valid = 1'b1; trap_pc = 32'h0000_0400; trap_cause = 32'h7; retired = 1'b1;
      tick();
      csr_w_enabled = 1'b0; trap_valid = 1'b0; retired = 1'b0;
      rd("rst_wr_ignored", 12'h340, 32'h0, 1'b0);
      rd("rst_trap_ign", 12'h341, 32'h0, 1'b0);
      rd("rst_ret_ign", 12'hB02, 32'h0, 1'b0);

      rstn = 1'b1;
      rd("release_mcycle", 12'hB00, 32'h0, 1'b0);
      rd("release_cycle", 12'hC00, 32'h0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         retired = ret_pat[i];
         tick();
      end
      retired = 1'b0;
      rd("mcycle_8", 12'hB00, 32'd8, 1'b0);
      rd("cycle_8", 12'hC00, 32'd8, 1'b0);
      rd("mcycleh_0", 12'hB80, 32'd0, 1'b0);
      rd("minstret_5", 12'hB02, 32'd5, 1'b0);
      rd("instret_5", 12'hC02, 32'd5, 1'b0);
      rd("instreth_0", 12'hC82, 32'd0, 1'b0);

      wr(12'hC02, 32'h0000_0055);
      rd("instret_ro", 12'hC02, 32'd5, 1'b0);
      rd("minstret_ro", 12'hB02, 32'd5, 1'b0);

      rd("misa", 12'h301, 32'h4000_0100, 1'b0);
      rd("mhartid", 12'hF14, 32'h0000_0005, 1'b0);
      rd("mip", 12'h344, 32'h0, 1'b0);

      // Same-cycle read sees the old value, next cycle sees the write
      csr_w_enabled = 1'b1; csr_w_addr = 12'h340; csr_w_data = 32'hDEAD_BEEF;
      rd("mscratch_old", 12'h340, 32'h0, 1'b0);
      tick();
      csr_w_enabled = 1'b0;
      rd("mscratch_new", 12'h340, 32'hDEAD_BEEF, 1'b0);

      wr(12'h305, 32'h0000_0007);
      rd("mtvec_align", 12'h305, 32'h0000_0004, 1'b0);
      chk("mtvec_out", mtvec_out, 32'h0000_0004);

      wr(12'h7C0, 32'h1234_5678);
      rd("unimpl_7c0", 12'h7C0, 32'h0, 1'b1);

      wr(12'h341, 32'h0000_0203);
      rd("mepc_align", 12'h341, 32'h0000_0200, 1'b0);
      chk("mepc_out_wr", mepc_out, 32'h0000_0200);

      wr(12'h304, 32'h0000_0888);
      wr(12'h343, 32'h0000_0077);
      rd("mie", 12'h304, 32'h0000_0888, 1'b0);
      rd("mtval", 12'h343, 32'h0000_0077, 1'b0);

      wr(12'h300, 32'hFFFF_FFFF);
      rd("mstatus_mask", 12'h300, 32'h0000_0088, 1'b0);
      wr(12'h300, 32'h0000_0008);
      rd("mstatus_mie", 12'h300, 32'h0000_0008, 1'b0);

      // Counter carry; the high-half write holds the low half
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0000_0000);
      rd("mcycle_hold", 12'hB00, 32'hFFFF_FFFF, 1'b0);
      rd("mcycleh_ld", 12'hB80, 32'h0, 1'b0);
      tick();
      rd("mcycle_carry", 12'hB00, 32'h0, 1'b0);
      rd("mcycleh_carry", 12'hB80, 32'h1, 1'b0);
      rd("cycleh_carry", 12'hC80, 32'h1, 1'b0);
      tick();
      rd("mcycle_after", 12'hB00, 32'h1, 1'b0);

      // Trap beats same-cycle mret and the mepc write
      trap_valid = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'h0000_000B; mret = 1'b1;
      csr_w_enabled = 1'b1; csr_w_addr = 12'h341; csr_w_data = 32'h0000_0300;
      tick();
      trap_valid = 1'b0; mret = 1'b0; csr_w_enabled = 1'b0;
      rd("trap_mepc", 12'h341, 32'h0000_0100, 1'b0);
      chk("trap_mepc_out", mepc_out, 32'h0000_0100);
      rd("trap_mcause", 12'h342, 32'h0000_000B, 1'b0);
      rd("trap_mstatus", 12'h300, 32'h0000_0080, 1'b0);
      rd("trap_mtvec", 12'h305, 32'h0000_0004, 1'b0);

      mret = 1'b1;
      tick();
      mret = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h0000_0088, 1'b0);

      // mret overrides a mstatus write
      mret = 1'b1;
      csr_w_enabled = 1'b1; csr_w_addr = 12'h300; csr_w_data = 32'h0;
      tick();
      mret = 1'b0; csr_w_enabled = 1'b0;
      rd("mret_vs_wr", 12'h300, 32'h0000_0088, 1'b0);

      // Unaffected CSR still takes a write during a trap
      trap_valid = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'h0000_0003;
      csr_w_enabled = 1'b1; csr_w_addr = 12'h340; csr_w_data = 32'hCAFE_F00D;
      tick();
      trap_valid = 1'b0; csr_w_enabled = 1'b0;
      rd("trap2_mscratch", 12'h340, 32'hCAFE_F00D, 1'b0);
      rd("trap2_mepc", 12'h341, 32'h0000_2000, 1'b0);
      rd("trap2_mcause", 12'h342, 32'h0000_0003, 1'b0);
      rd("trap2_mstatus", 12'h300, 32'h0000_0080, 1'b0);

      retired = 1'b1;
      tick(); tick();
      retired = 1'b0;
      rd("minstret_7", 12'hB02, 32'd7, 1'b0);

      // One-cycle reset mid-count with a trap pending
      rstn = 1'b0;
      trap_valid = 1'b1; trap_pc = 32'h0000_0444; trap_cause = 32'h0000_0002;
      csr_w_enabled = 1'b1; csr_w_addr = 12'h340; csr_w_data = 32'h0000_0099;
      tick();
      rstn = 1'b1; trap_valid = 1'b0; csr_w_enabled = 1'b0;
      rd("rst2_mcycle", 12'hB00, 32'h0, 1'b0);
      rd("rst2_minstret", 12'hB02, 32'h0, 1'b0);
      rd("rst2_mstatus", 12'h300, 32'h0, 1'b0);
      rd("rst2_mie", 12'h304, 32'h0, 1'b0);
      rd("rst2_mtvec", 12'h305, 32'h0, 1'b0);
      rd("rst2_mscratch", 12'h340, 32'h0, 1'b0);
      rd("rst2_mepc", 12'h341, 32'h0, 1'b0);
      rd("rst2_mcause", 12'h342, 32'h0, 1'b0);
      rd("rst2_mtval", 12'h343, 32'h0, 1'b0);
      chk("rst2_mtvec_out", mtvec_out, 32'h0);
      chk("rst2_mepc_out", mepc_out, 32'h0);
      tick();
      rd("rst2_mcycle_1", 12'hB00, 32'h1, 1'b0);
      tick();
      rd("rst2_mcycle_2", 12'hB00, 32'h2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
